// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
interface mem_access_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    dmem_req;
   logic                    dmem_we;
   logic [DATA_WIDTH-1:0]   dmem_addr;
   logic [3:0]              dmem_be;
   logic [DATA_WIDTH-1:0]   dmem_wdata;
   logic [DATA_WIDTH-1:0]   dmem_rdata;
   logic                    dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: fault check, byte-lane steering, request/ack
// transaction with timeout, and load-data extension for MEM/WB.
module mem_access_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  memread_m,
   input  logic                  memwrite_m,
   input  logic [2:0]            funct3_m,
   input  logic [DATA_WIDTH-1:0] aluresult_m,
   input  logic [DATA_WIDTH-1:0] writedata_m,
   output logic [DATA_WIDTH-1:0] readdata_m,
   output logic                  stall_m,
   output logic                  misaligned_m,
   output logic                  bus_err_m,
   mem_access_unit_if.master     dmem
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_next;
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]              a_lo;
   logic [2:0]              f3_q;
   logic                    load_q;
   logic                    err_q;

   logic                    access;
   logic                    is_store;
   logic                    fault;
   logic                    start;
   logic [3:0]              be_c;
   logic [DATA_WIDTH-1:0]   wdata_c;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [DATA_WIDTH-1:0]   load_ext;

   // Decode the incoming instruction: legality, byte enables and store lanes.
   always_comb begin
      access   = memread_m | memwrite_m;
      is_store = memwrite_m;
      fault    = 1'b0;
      be_c     = 4'b0000;
      wdata_c  = writedata_m;
      case (funct3_m)
         3'b000, 3'b100: begin
            be_c    = 4'b0001 << aluresult_m[1:0];
            wdata_c = {4{writedata_m[7:0]}};
            if (is_store && funct3_m[2]) fault = 1'b1;
         end
         3'b001, 3'b101: begin
            be_c    = 4'b0011 << aluresult_m[1:0];
            wdata_c = {2{writedata_m[15:0]}};
            if (aluresult_m[0]) fault = 1'b1;
            if (is_store && funct3_m[2]) fault = 1'b1;
         end
         3'b010: begin
            be_c    = 4'b1111;
            wdata_c = writedata_m;
            if (aluresult_m[1:0] != 2'b00) fault = 1'b1;
         end
         default: fault = 1'b1;
      endcase
      start = access & ~fault;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and pipeline-facing status outputs.
   always_comb begin
      state_next   = state;
      stall_m      = 1'b0;
      misaligned_m = 1'b0;
      bus_err_m    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = BUSY;
               stall_m    = 1'b1;
            end else if (access) begin
               misaligned_m = 1'b1;
            end
         end
         BUSY: begin
            stall_m = 1'b1;
            if (dmem.dmem_ack || cnt == CNT_LAST) state_next = DONE;
         end
         DONE: begin
            bus_err_m  = err_q;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (!rst_n) begin
         stall_m      = 1'b0;
         misaligned_m = 1'b0;
         bus_err_m    = 1'b0;
      end
   end

   // Request registers, timeout counter, read-data capture and error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_be    <= '0;
         dmem.dmem_wdata <= '0;
         cnt             <= '0;
         rdata_q         <= '0;
         err_q           <= 1'b0;
         a_lo            <= 2'b00;
         f3_q            <= 3'b000;
         load_q          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= is_store;
                  dmem.dmem_addr  <= {aluresult_m[DATA_WIDTH-1:2], 2'b00};
                  dmem.dmem_be    <= be_c;
                  dmem.dmem_wdata <= wdata_c;
                  a_lo            <= aluresult_m[1:0];
                  f3_q            <= funct3_m;
                  load_q          <= ~is_store;
                  cnt             <= '0;
                  rdata_q         <= '0;
                  err_q           <= 1'b0;
               end
            end
            BUSY: begin
               if (dmem.dmem_ack) begin
                  dmem.dmem_req <= 1'b0;
                  if (load_q) rdata_q <= dmem.dmem_rdata;
               end else if (cnt == CNT_LAST) begin
                  dmem.dmem_req <= 1'b0;
                  err_q         <= 1'b1;
                  rdata_q       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // Load extraction from the captured word using the registered offset.
   always_comb begin
      case (a_lo)
         2'd0:    byte_sel = rdata_q[7:0];
         2'd1:    byte_sel = rdata_q[15:8];
         2'd2:    byte_sel = rdata_q[23:16];
         default: byte_sel = rdata_q[31:24];
      endcase
      half_sel = a_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'h000000, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'h0000, half_sel};
         default: load_ext = rdata_q;
      endcase
      readdata_m = (rst_n && state == DONE && load_q) ? load_ext : '0;
   end

endmodule
